// File: rtl/elixirchip_es1_spu_pkg.sv
// Shared SPU types: memory request payload, read-return tag, arbiter limits.
package elixirchip_es1_spu_pkg;

  localparam int unsigned SPU_MEM_MAX_PORTS     = 8;
  localparam int unsigned SPU_MEM_MAX_PORT_BITS = $clog2(SPU_MEM_MAX_PORTS);
  localparam int unsigned SPU_MEM_MAX_ADDR_BITS = 32;
  localparam int unsigned SPU_MEM_MAX_DATA_BITS = 64;

  // Lane-side request payload, sized for the widest memory op in the SPU
  typedef struct packed {
    logic                             we;
    logic [SPU_MEM_MAX_ADDR_BITS-1:0] addr;
    logic [SPU_MEM_MAX_DATA_BITS-1:0] wdata;
  } spu_mem_req_t;

  typedef struct packed {
    logic                             valid;
    logic [SPU_MEM_MAX_PORT_BITS-1:0] port;
  } spu_rd_tag_t;

endpackage

// File: rtl/elixirchip_es1_spu_ctl_rr_grant.sv
// Combinational picker: first requester above i_ptr (wrapping) wins, one-hot grant plus index.
module elixirchip_es1_spu_ctl_rr_grant #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned PORT_BITS = 1
) (
  input  logic                 i_en,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [PORT_BITS-1:0] i_ptr,
  output logic [NUM_PORTS-1:0] o_grant,
  output logic [PORT_BITS-1:0] o_idx,
  output logic                 o_any
);

  always_comb begin
    logic [PORT_BITS-1:0] w_c;
    logic                 w_found;
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_c     = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      w_c = PORT_BITS'((32'(i_ptr) + 32'd1 + k) % NUM_PORTS);
      if (i_en && !w_found && i_req[w_c]) begin
        o_grant[w_c] = 1'b1;
        o_idx        = w_c;
        w_found      = 1'b1;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/elixirchip_es1_spu_ctl_mem_arbiter.sv
// Multi-requester arbiter/sequencer for one shared SPU simple-dual-port memory op.
// Define ELIXIRCHIP_SPU_MEM_ARB_FIXED_PRIORITY_EN for fixed lowest-index priority instead of round-robin.
module elixirchip_es1_spu_ctl_mem_arbiter
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned WLATENCY  = 1,
  parameter int unsigned RLATENCY  = 1,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned ADDR_BITS = 9,
  parameter int unsigned PORT_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cke,
  input  logic [NUM_PORTS-1:0]           s_valid,
  input  logic [NUM_PORTS-1:0]           s_we,
  input  logic [NUM_PORTS*ADDR_BITS-1:0] s_addr,
  input  logic [NUM_PORTS*DATA_BITS-1:0] s_wdata,
  output logic [NUM_PORTS-1:0]           s_ready,
  output logic [NUM_PORTS-1:0]           m_rvalid,
  output logic [DATA_BITS-1:0]           m_rdata,
  output logic [ADDR_BITS-1:0]           mem_waddr,
  output logic [DATA_BITS-1:0]           mem_wdata,
  output logic                           mem_wvalid,
  output logic [ADDR_BITS-1:0]           mem_raddr,
  output logic                           mem_rvalid,
  input  logic [DATA_BITS-1:0]           mem_rdata
);

  if (NUM_PORTS < 2 || NUM_PORTS > SPU_MEM_MAX_PORTS) begin : g_bad_ports
    $error("NUM_PORTS out of range");
  end
  if (WLATENCY < 1 || RLATENCY < 1) begin : g_bad_latency
    $error("WLATENCY and RLATENCY must be >= 1");
  end

  logic [NUM_PORTS-1:0] w_grant;
  logic [PORT_BITS-1:0] w_idx;
  logic                 w_any;
  logic [PORT_BITS-1:0] w_ptr;
  logic                 w_we;
  logic [ADDR_BITS-1:0] w_addr;
  logic [DATA_BITS-1:0] w_wdata;
  logic [NUM_PORTS-1:0] w_tag_rv;
  spu_rd_tag_t          w_tag_out;

  logic                 r_mem_wvalid;
  logic                 r_mem_rvalid;
  logic [ADDR_BITS-1:0] r_mem_waddr;
  logic [ADDR_BITS-1:0] r_mem_raddr;
  logic [DATA_BITS-1:0] r_mem_wdata;
  logic [PORT_BITS-1:0] r_rd_port;
  logic [NUM_PORTS-1:0] r_m_rvalid;
  logic [DATA_BITS-1:0] r_m_rdata;
  spu_rd_tag_t          r_tag [RLATENCY];

`ifdef ELIXIRCHIP_SPU_MEM_ARB_FIXED_PRIORITY_EN
  // Pointer pinned at the top index so the search always starts at port 0
  assign w_ptr = PORT_BITS'(NUM_PORTS - 1);
`else
  logic [PORT_BITS-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= PORT_BITS'(NUM_PORTS - 1);
    end else if (cke && w_any) begin
      r_ptr <= w_idx;
    end
  end

  assign w_ptr = r_ptr;
`endif

  elixirchip_es1_spu_ctl_rr_grant #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_BITS (PORT_BITS)
  ) u_grant (
    .i_en    (cke & ~reset),
    .i_req   (s_valid),
    .i_ptr   (w_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Winner's request fields
  always_comb begin
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (w_grant[i]) begin
        w_we    = s_we[i];
        w_addr  = s_addr[i*ADDR_BITS +: ADDR_BITS];
        w_wdata = s_wdata[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  assign w_tag_out = r_tag[RLATENCY-1];

  always_comb begin
    w_tag_rv = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (w_tag_out.valid && w_tag_out.port == SPU_MEM_MAX_PORT_BITS'(i)) begin
        w_tag_rv[i] = 1'b1;
      end
    end
  end

  // Memory-port stage, read tag pipeline and read return; everything frozen while cke=0
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_wvalid <= 1'b0;
      r_mem_rvalid <= 1'b0;
      r_mem_waddr  <= '0;
      r_mem_raddr  <= '0;
      r_mem_wdata  <= '0;
      r_rd_port    <= '0;
      r_m_rvalid   <= '0;
      r_m_rdata    <= '0;
      for (int unsigned i = 0; i < RLATENCY; i++) begin
        r_tag[i] <= '0;
      end
    end else if (cke) begin
      if (w_any && w_we) begin
        r_mem_wvalid <= 1'b1;
        r_mem_rvalid <= 1'b0;
        r_mem_waddr  <= w_addr;
        r_mem_wdata  <= w_wdata;
      end else if (w_any) begin
        r_mem_wvalid <= 1'b0;
        r_mem_rvalid <= 1'b1;
        r_mem_raddr  <= w_addr;
        r_rd_port    <= w_idx;
      end else begin
        r_mem_wvalid <= 1'b0;
        r_mem_rvalid <= 1'b0;
      end
      r_tag[0].valid <= r_mem_rvalid;
      r_tag[0].port  <= SPU_MEM_MAX_PORT_BITS'(r_rd_port);
      for (int unsigned i = 1; i < RLATENCY; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
      r_m_rvalid <= w_tag_rv;
      if (w_tag_out.valid) begin
        r_m_rdata <= mem_rdata;
      end
    end
  end

  assign s_ready    = w_grant;
  assign m_rvalid   = r_m_rvalid;
  assign m_rdata    = r_m_rdata;
  assign mem_waddr  = r_mem_waddr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_wvalid = r_mem_wvalid;
  assign mem_raddr  = r_mem_raddr;
  assign mem_rvalid = r_mem_rvalid;

endmodule

// File: tb/tb_elixirchip_es1_spu_ctl_mem_arbiter.sv
// Self-checking bench: 2-port/RLATENCY=1 vector table plus 4-port/RLATENCY=3 directed sequence.
module tb_elixirchip_es1_spu_ctl_mem_arbiter;

`ifdef ELIXIRCHIP_SPU_MEM_ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- 2-port instance, RLATENCY=1 ----------------
  logic        reset2, cke2;
  logic [1:0]  s2_valid, s2_we, s2_ready, m2_rvalid;
  logic [17:0] s2_addr;
  logic [15:0] s2_wdata;
  logic [7:0]  m2_rdata, m2_wdata, m2_mem_rdata;
  logic [8:0]  m2_waddr, m2_raddr;
  logic        m2_wvalid, m2_rv;
  logic [7:0]  mem2 [512];

  elixirchip_es1_spu_ctl_mem_arbiter #(
    .NUM_PORTS(2), .WLATENCY(1), .RLATENCY(1), .DATA_BITS(8), .ADDR_BITS(9)
  ) u_dut2 (
    .clk(clk), .reset(reset2), .cke(cke2),
    .s_valid(s2_valid), .s_we(s2_we), .s_addr(s2_addr), .s_wdata(s2_wdata),
    .s_ready(s2_ready), .m_rvalid(m2_rvalid), .m_rdata(m2_rdata),
    .mem_waddr(m2_waddr), .mem_wdata(m2_wdata), .mem_wvalid(m2_wvalid),
    .mem_raddr(m2_raddr), .mem_rvalid(m2_rv), .mem_rdata(m2_mem_rdata)
  );

  always @(posedge clk) begin
    if (cke2) begin
      if (m2_wvalid) mem2[m2_waddr] <= m2_wdata;
      m2_mem_rdata <= mem2[m2_raddr];
    end
  end

  // ---------------- 4-port instance, RLATENCY=3 ----------------
  logic        reset4, cke4;
  logic [3:0]  s4_valid, s4_we, s4_ready, m4_rvalid;
  logic [35:0] s4_addr;
  logic [31:0] s4_wdata;
  logic [7:0]  m4_rdata, m4_wdata, m4_mem_rdata, rd4_0, rd4_1;
  logic [8:0]  m4_waddr, m4_raddr;
  logic        m4_wvalid, m4_rv;
  logic [7:0]  mem4 [512];

  elixirchip_es1_spu_ctl_mem_arbiter #(
    .NUM_PORTS(4), .WLATENCY(1), .RLATENCY(3), .DATA_BITS(8), .ADDR_BITS(9)
  ) u_dut4 (
    .clk(clk), .reset(reset4), .cke(cke4),
    .s_valid(s4_valid), .s_we(s4_we), .s_addr(s4_addr), .s_wdata(s4_wdata),
    .s_ready(s4_ready), .m_rvalid(m4_rvalid), .m_rdata(m4_rdata),
    .mem_waddr(m4_waddr), .mem_wdata(m4_wdata), .mem_wvalid(m4_wvalid),
    .mem_raddr(m4_raddr), .mem_rvalid(m4_rv), .mem_rdata(m4_mem_rdata)
  );

  always @(posedge clk) begin
    if (cke4) begin
      if (m4_wvalid) mem4[m4_waddr] <= m4_wdata;
      rd4_0        <= mem4[m4_raddr];
      rd4_1        <= rd4_0;
      m4_mem_rdata <= rd4_1;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       cke;
    logic [1:0] valid;
    logic [1:0] we;
    logic [8:0] a0;
    logic [8:0] a1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] x_ready;
    logic       x_mw;
    logic       x_mr;
    logic [1:0] x_rv;
    logic       chk_rd;
    logic [7:0] x_rd;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic rst, input logic cke, input logic [1:0] valid, input logic [1:0] we,
                     input logic [8:0] a0, input logic [8:0] a1, input logic [7:0] d0, input logic [7:0] d1,
                     input logic [1:0] xr, input logic xmw, input logic xmr, input logic [1:0] xrv,
                     input logic chkr, input logic [7:0] xrd);
    vec_t v;
    v.rst = rst; v.cke = cke; v.valid = valid; v.we = we; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.x_ready = xr; v.x_mw = xmw; v.x_mr = xmr; v.x_rv = xrv; v.chk_rd = chkr; v.x_rd = xrd;
    vt.push_back(v);
  endtask

  task automatic idle2(input logic cke, input logic [1:0] xrv, input logic chkr, input logic [7:0] xrd);
    add(1'b0, cke, 2'b00, 2'b00, 9'd0, 9'd0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, xrv, chkr, xrd);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem2[i] = 8'h00;
      mem4[i] = 8'h00;
    end
    mem2[6] = 8'h66; mem2[7] = 8'h77;
    mem4[1] = 8'h11; mem4[3] = 8'h33;

    // Port0 write 5=A5, port1 reads it back 3 cycles later
    add(0, 1, 2'b01, 2'b01, 9'd5, 9'd0, 8'hA5, 8'h00, 2'b01, 1, 0, 2'b00, 1, 8'h00);
    idle2(1, 2'b00, 0, 8'h00);
    idle2(1, 2'b00, 0, 8'h00);
    add(0, 1, 2'b10, 2'b00, 9'd0, 9'd5, 8'h00, 8'h00, 2'b10, 0, 1, 2'b00, 0, 8'h00);
    idle2(1, 2'b00, 0, 8'h00);
    idle2(1, 2'b10, 1, 8'hA5);
    idle2(1, 2'b00, 1, 8'hA5);
    // Both ports reading continuously: alternation (round-robin) or port0 always (fixed)
    add(0, 1, 2'b11, 2'b00, 9'd6, 9'd7, 0, 0, 2'b01, 0, 1, 2'b00, 0, 8'h00);
    add(0, 1, 2'b11, 2'b00, 9'd6, 9'd7, 0, 0, FIXED ? 2'b01 : 2'b10, 0, 1, 2'b00, 0, 8'h00);
    add(0, 1, 2'b11, 2'b00, 9'd6, 9'd7, 0, 0, 2'b01, 0, 1, 2'b01, 1, 8'h66);
    add(0, 1, 2'b11, 2'b00, 9'd6, 9'd7, 0, 0, FIXED ? 2'b01 : 2'b10, 0, 1,
        FIXED ? 2'b01 : 2'b10, 1, FIXED ? 8'h66 : 8'h77);
    idle2(1, 2'b01, 1, 8'h66);
    idle2(1, FIXED ? 2'b01 : 2'b10, 1, FIXED ? 8'h66 : 8'h77);
    idle2(1, 2'b00, 0, 8'h00);
    // Read in flight while cke low for 3 cycles
    add(0, 1, 2'b01, 2'b00, 9'd6, 9'd0, 0, 0, 2'b01, 0, 1, 2'b00, 0, 8'h00);
    add(0, 0, 2'b01, 2'b00, 9'd6, 9'd0, 0, 0, 2'b00, 0, 1, 2'b00, 0, 8'h00);
    add(0, 0, 2'b01, 2'b00, 9'd6, 9'd0, 0, 0, 2'b00, 0, 1, 2'b00, 0, 8'h00);
    add(0, 0, 2'b01, 2'b00, 9'd6, 9'd0, 0, 0, 2'b00, 0, 1, 2'b00, 0, 8'h00);
    idle2(1, 2'b00, 0, 8'h00);
    idle2(1, 2'b01, 1, 8'h66);
    idle2(0, 2'b01, 1, 8'h66);
    idle2(1, 2'b00, 1, 8'h66);
    // Reset one cycle after a port0 read grant: read dropped, port0 priority restored
    add(0, 1, 2'b01, 2'b00, 9'd6, 9'd0, 0, 0, 2'b01, 0, 1, 2'b00, 0, 8'h00);
    add(1, 1, 2'b11, 2'b00, 9'd6, 9'd7, 0, 0, 2'b00, 0, 0, 2'b00, 1, 8'h00);
    idle2(1, 2'b00, 1, 8'h00);
    idle2(1, 2'b00, 1, 8'h00);
    add(0, 1, 2'b11, 2'b00, 9'd6, 9'd7, 0, 0, 2'b01, 0, 1, 2'b00, 0, 8'h00);
    idle2(1, 2'b00, 0, 8'h00);
    idle2(1, 2'b01, 1, 8'h66);
    // Port1 write to check the data mux
    add(0, 1, 2'b10, 2'b10, 9'd0, 9'd9, 8'h00, 8'h3C, 2'b10, 1, 0, 2'b00, 1, 8'h66);

    // Reset state
    reset2 = 1; cke2 = 1; s2_valid = 2'b11; s2_we = 0; s2_addr = '0; s2_wdata = '0;
    reset4 = 1; cke4 = 1; s4_valid = 4'b0000; s4_we = 0; s4_addr = '0; s4_wdata = '0;
    #1;
    chk("reset s_ready", 32'(s2_ready), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    chk("reset mem_wvalid", 32'(m2_wvalid), 32'h0);
    chk("reset mem_rvalid", 32'(m2_rv), 32'h0);
    chk("reset m_rvalid", 32'(m2_rvalid), 32'h0);
    chk("reset m_rdata", 32'(m2_rdata), 32'h0);
    chk("reset mem_waddr", 32'(m2_waddr), 32'h0);
    chk("reset mem_raddr", 32'(m2_raddr), 32'h0);
    chk("reset mem_wdata", 32'(m2_wdata), 32'h0);

    foreach (vt[i]) begin
      reset2   = vt[i].rst;
      cke2     = vt[i].cke;
      s2_valid = vt[i].valid;
      s2_we    = vt[i].we;
      s2_addr  = {vt[i].a1, vt[i].a0};
      s2_wdata = {vt[i].d1, vt[i].d0};
      #1;
      chk($sformatf("v%0d s_ready", i), 32'(s2_ready), 32'(vt[i].x_ready));
      @(posedge clk); #1;
      chk($sformatf("v%0d mem_wvalid", i), 32'(m2_wvalid), 32'(vt[i].x_mw));
      chk($sformatf("v%0d mem_rvalid", i), 32'(m2_rv), 32'(vt[i].x_mr));
      chk($sformatf("v%0d m_rvalid", i), 32'(m2_rvalid), 32'(vt[i].x_rv));
      if (vt[i].chk_rd) chk($sformatf("v%0d m_rdata", i), 32'(m2_rdata), 32'(vt[i].x_rd));
    end
    s2_valid = 0;
    chk("p1 write mem_waddr", 32'(m2_waddr), 32'd9);
    chk("p1 write mem_wdata", 32'(m2_wdata), 32'h3C);
    chk("mem_raddr holds", 32'(m2_raddr), 32'd6);

    // 4-port, RLATENCY=3: ports 1 and 3 read back-to-back
    reset4 = 0;
    @(posedge clk); #1;
    s4_valid = 4'b1010; s4_we = 4'b0000; s4_addr = {9'd3, 9'd0, 9'd1, 9'd0};
    #1;
    chk("p4 grant A", 32'(s4_ready), 32'h2);
    @(posedge clk); #1;
    chk("p4 raddr A", 32'(m4_raddr), 32'd1);
    s4_valid = 4'b1000;
    #1;
    chk("p4 grant B", 32'(s4_ready), 32'h8);
    @(posedge clk); #1;
    chk("p4 raddr B", 32'(m4_raddr), 32'd3);
    s4_valid = 4'b0000;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("p4 rd k%0d m_rvalid", k), 32'(m4_rvalid),
          (k == 2) ? 32'h2 : (k == 3) ? 32'h8 : 32'h0);
      if (k == 2) chk("p4 rd port1 data", 32'(m4_rdata), 32'h11);
      if (k == 3) chk("p4 rd port3 data", 32'(m4_rdata), 32'h33);
    end

    // Port2 writes 1FF=C3, port0 reads it 2 cycles later
    s4_valid = 4'b0100; s4_we = 4'b0100; s4_addr = {9'd0, 9'h1FF, 9'd0, 9'd0}; s4_wdata = {8'h00, 8'hC3, 16'h0000};
    #1;
    chk("p4 grant W", 32'(s4_ready), 32'h4);
    @(posedge clk); #1;
    chk("p4 mem_wvalid", 32'(m4_wvalid), 32'h1);
    chk("p4 mem_waddr", 32'(m4_waddr), 32'h1FF);
    chk("p4 mem_wdata", 32'(m4_wdata), 32'hC3);
    s4_valid = 4'b0000; s4_we = 4'b0000;
    @(posedge clk); #1;
    s4_valid = 4'b0001; s4_addr = {27'd0, 9'h1FF};
    #1;
    chk("p4 grant R", 32'(s4_ready), 32'h1);
    @(posedge clk); #1;
    s4_valid = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("p4 raw k%0d m_rvalid", k), 32'(m4_rvalid), (k == 3) ? 32'h1 : 32'h0);
      if (k == 3) chk("p4 raw data", 32'(m4_rdata), 32'hC3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/elixirchip_es1_spu_ctl_mem_arbiter.md
Name: elixirchip_es1_spu_ctl_mem_arbiter

Overview:
Multi-requester arbiter and sequencer for one shared SPU simple-dual-port memory op (write port plus registered read port, latencies WLATENCY/RLATENCY).
- Accepts one read-or-write request per cke cycle from NUM_PORTS requesters.
- Registers the winner onto the memory ports.
- Tracks read latency so each read result returns to the requester that issued it.
- Sits between SPU op lanes and the memory op; the memory op itself is instantiated outside this block.

Parameters:
NUM_PORTS, 2, number of requesters (2..8)
WLATENCY, 1, memory op write latency (>=1)
RLATENCY, 1, memory op read latency (>=1)
DATA_BITS, 8, data width
ADDR_BITS, 9, address width
PORT_BITS, $clog2(NUM_PORTS) (min 1), requester index width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cke  in  1  clock enable; all state frozen when 0
s_valid  in  NUM_PORTS  per-port request valid
s_we  in  NUM_PORTS  per-port 1=write, 0=read
s_addr  in  NUM_PORTS*ADDR_BITS  per-port address, port i in bits [i*ADDR_BITS +: ADDR_BITS]
s_wdata  in  NUM_PORTS*DATA_BITS  per-port write data
s_ready  out  NUM_PORTS  one-hot grant; request accepted when s_valid[i] && s_ready[i] && cke
m_rvalid  out  NUM_PORTS  per-port read-data valid (one-hot or zero)
m_rdata  out  DATA_BITS  read data, shared by all ports
mem_waddr  out  ADDR_BITS  to memory op write address
mem_wdata  out  DATA_BITS  to memory op write data
mem_wvalid  out  1  to memory op write valid
mem_raddr  out  ADDR_BITS  to memory op read address
mem_rvalid  out  1  to memory op read valid
mem_rdata  in  DATA_BITS  from memory op read data

Behaviour:
- Reset values: mem_wvalid=0, mem_rvalid=0, mem_waddr/mem_raddr/mem_wdata=0, m_rvalid=0, m_rdata=0, round-robin pointer=NUM_PORTS-1, so port 0 has priority first.
- s_ready is combinational from s_valid, the pointer and cke.
  - cke=0 or reset=1: s_ready=0.
  - Otherwise exactly one bit is set: the first valid port searched from pointer+1 upward, wrapping modulo NUM_PORTS. No valid port gives s_ready=0.
- On acceptance (cke=1), registered update:
  - Pointer takes the granted index.
  - Write: mem_wvalid=1, mem_waddr/mem_wdata loaded, mem_rvalid=0.
  - Read: mem_rvalid=1, mem_raddr loaded, mem_wvalid=0.
- No acceptance with cke=1: mem_wvalid=0 and mem_rvalid=0. Address/data registers hold.
- Pointer holds when nothing is granted. A lone requester is granted every cycle (100% throughput).
- Read tag pipeline: shift register of depth RLATENCY, entries {valid, port index}, advances only when cke=1, fed from the registered mem_rvalid stage.
  - At the pipeline output: m_rvalid[idx]=valid, and m_rdata is captured from mem_rdata.
  - Read latency from s_valid&&s_ready to m_rvalid = 1+RLATENCY cke cycles.
  - Write reaches the array 1+WLATENCY cke cycles after acceptance.
- Hazard: no read-after-write forwarding. A read to the same address issued fewer than WLATENCY+1 cycles after the write returns old data. Callers handle this.
- cke=0 mid-operation: no grant, no shift, all outputs hold their values (including m_rvalid).
- Reset mid-operation: in-flight reads are discarded (tags cleared). m_rvalid stays 0 until new reads complete.
- Simultaneous read and write requests from different ports: only one is granted per cycle. The write/read type does not affect priority.

Optional Feature:
Macro ELIXIRCHIP_SPU_MEM_ARB_FIXED_PRIORITY_EN.
- Defined: fixed priority, lowest valid index wins. The pointer register is removed.
- Undefined: round-robin as described above.
- Latency, tagging and reset behaviour are identical in both cases.

Decomposition:
- Shared package elixirchip_es1_spu_pkg holds:
  - typedef spu_mem_req_t {we, addr, wdata}
  - typedef spu_rd_tag_t {valid, port index}
  - constant SPU_MEM_MAX_PORTS = 8
- One sub-module: elixirchip_es1_spu_ctl_rr_grant, the combinational round-robin/priority picker (request vector + pointer -> one-hot grant + index).

Test Plan:
- Reset, then port0 writes addr 5 = 0xA5, then port1 reads addr 5 three cycles later (RLATENCY=1) -> m_rvalid=2'b10 exactly 2 cycles after the read grant, m_rdata=0xA5.
- Both ports valid continuously with reads -> s_ready alternates 01,10,01,10. Each port receives its own tagged m_rvalid in issue order.
- NUM_PORTS=4, RLATENCY=3, ports 1 and 3 read addrs 1 and 3 (preloaded 0x11/0x33) back-to-back -> m_rvalid=0010 with 0x11, then 1000 with 0x33, 4 cycles after each grant.
- cke held low for 3 cycles while a read is in flight -> no outputs change. The result appears after 1+RLATENCY cke-high cycles.
- reset asserted one cycle after a read grant -> no m_rvalid for that read. Pointer is back to port-0 priority.
- Macro defined, ports 0 and 1 both valid for 4 cycles -> s_ready=01 every cycle.
